// File: rtl/game_pkg.sv
// Shared definitions for the falling-block scoring logic.
package game_pkg;
   localparam int LANES = 4;
   localparam int SCORE_W = 8;
   localparam logic [SCORE_W-1:0] SCORE_MAX = 8'hFF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      HIT   = 2'd2
   } lane_state_t;
endpackage

// File: rtl/lane_judge.sv
// One lane: key synchronizer, press edge detect, window judge FSM and
// hit-flash stretcher. Hit strobe is registered; miss/stray strobes come
// straight from the FSM so the parent can count them on the same edge.
module lane_judge
   import game_pkg::*;
#(
   parameter int FLASH_CYCLES = 5000000,
   parameter int FLASH_W      = 23
) (
   input  logic clock,
   input  logic resetn,
   input  logic i_pe,
   input  logic i_key_n,
   output logic o_hit,
   output logic o_miss,
   output logic o_stray,
   output logic o_flash
);
   logic               r_sync1, r_sync2, r_sync_prev;
   logic               w_press;
   lane_state_t        r_state, w_state_nxt;
   logic               w_hit_nxt, w_miss, w_stray;
   logic               r_hit;
   logic [FLASH_W-1:0] r_flash_cnt;

   // 2-FF synchronizer plus one delay stage for edge detection; released = 1
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_sync1     <= 1'b1;
         r_sync2     <= 1'b1;
         r_sync_prev <= 1'b1;
      end else begin
         r_sync1     <= i_key_n;
         r_sync2     <= r_sync1;
         r_sync_prev <= r_sync2;
      end
   end

   // falling edge of the synchronized key: one cycle per physical press
   assign w_press = r_sync_prev & ~r_sync2;

   // lane state register
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) r_state <= IDLE;
      else         r_state <= w_state_nxt;
   end

   // window judge: closing window beats a same-cycle press (counts as miss)
   always_comb begin
      w_state_nxt = r_state;
      w_hit_nxt   = 1'b0;
      w_miss      = 1'b0;
      w_stray     = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_pe) begin
               if (w_press) begin
                  w_state_nxt = HIT;
                  w_hit_nxt   = 1'b1;
               end else begin
                  w_state_nxt = ARMED;
               end
            end else if (w_press) begin
               w_stray = 1'b1;
            end
         end
         ARMED: begin
            if (!i_pe) begin
               w_state_nxt = IDLE;
               w_miss      = 1'b1;
            end else if (w_press) begin
               w_state_nxt = HIT;
               w_hit_nxt   = 1'b1;
            end
         end
         HIT: begin
            if (!i_pe) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // registered hit strobe, high exactly one cycle
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) r_hit <= 1'b0;
      else         r_hit <= w_hit_nxt;
   end

   // flash stretcher: reload on every hit, count down to zero
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)                  r_flash_cnt <= '0;
      else if (r_hit)               r_flash_cnt <= FLASH_W'(FLASH_CYCLES);
      else if (r_flash_cnt != '0)   r_flash_cnt <= r_flash_cnt - 1'b1;
   end

   assign o_hit   = r_hit;
   assign o_miss  = w_miss;
   assign o_stray = w_stray;
   assign o_flash = (r_flash_cnt != '0);
endmodule

// File: rtl/hit_judge.sv
// Scoring top: per-lane judges, event counting across all lanes in one
// cycle, clamped score and saturating miss counter.
module hit_judge
   import game_pkg::*;
#(
   parameter int LANES        = game_pkg::LANES,
   parameter int PENALTY      = 1,
   parameter int FLASH_CYCLES = 5000000,
   parameter int FLASH_W      = 23
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic [LANES-1:0]   pressEnable,
   input  logic [LANES-1:0]   key_n,
   output logic [SCORE_W-1:0] score,
   output logic [SCORE_W-1:0] miss_count,
   output logic [LANES-1:0]   hit_flash,
   output logic [LANES-1:0]   hit_pulse
);
   localparam int CW = $clog2(LANES + 1);

   logic [LANES-1:0]   w_hit, w_miss, w_stray;
   logic [CW-1:0]      w_nh, w_ns, w_nm;
   logic signed [9:0]  w_sum;
   logic [8:0]         w_mc;
   logic [SCORE_W-1:0] w_score_nxt, w_miss_nxt;
   logic [SCORE_W-1:0] r_score, r_miss_cnt;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      lane_judge #(
         .FLASH_CYCLES (FLASH_CYCLES),
         .FLASH_W      (FLASH_W)
      ) u_lane (
         .clock   (clock),
         .resetn  (resetn),
         .i_pe    (pressEnable[g]),
         .i_key_n (key_n[g]),
         .o_hit   (w_hit[g]),
         .o_miss  (w_miss[g]),
         .o_stray (w_stray[g]),
         .o_flash (hit_flash[g])
      );
   end

   // count events of all lanes, then apply them in one signed update
   always_comb begin
      w_nh = '0;
      w_ns = '0;
      w_nm = '0;
      for (int i = 0; i < LANES; i++) begin
         w_nh = w_nh + CW'(w_hit[i]);
         w_ns = w_ns + CW'(w_stray[i]);
         w_nm = w_nm + CW'(w_miss[i]);
      end
      w_sum = 10'(r_score) + 10'(w_nh) - 10'(PENALTY) * 10'(w_ns);
      if (w_sum[9])      w_score_nxt = '0;
      else if (w_sum[8]) w_score_nxt = SCORE_MAX;
      else               w_score_nxt = w_sum[7:0];
      w_mc = 9'(r_miss_cnt) + 9'(w_nm);
      w_miss_nxt = w_mc[8] ? SCORE_MAX : w_mc[7:0];
   end

   // score and miss registers
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_score    <= '0;
         r_miss_cnt <= '0;
      end else begin
         r_score    <= w_score_nxt;
         r_miss_cnt <= w_miss_nxt;
      end
   end

   assign score      = r_score;
   assign miss_count = r_miss_cnt;
   assign hit_pulse  = w_hit;
endmodule

// File: tb/tb_hit_judge.sv
// Bench for hit_judge: directed scenarios plus random key/window traffic,
// all checked every cycle against a window-level reference model.
module tb_hit_judge;
   localparam int L   = 4;
   localparam int PEN = 1;
   localparam int FC  = 8;

   logic         clock = 1'b0;
   logic         resetn = 1'b1;
   logic [L-1:0] pe = '0;
   logic [L-1:0] kn = '1;
   logic [7:0]   score, miss_count;
   logic [L-1:0] hit_flash, hit_pulse;

   int n_chk = 0;
   int n_fail = 0;

   // reference model state: window open/scored flags, key history, outputs
   int m_score, m_miss;
   int m_flash [L];
   bit m_hp [L];
   bit m_open [L], m_got [L];
   bit h1 [L], h2 [L], h3 [L];

   hit_judge #(
      .LANES(L), .PENALTY(PEN), .FLASH_CYCLES(FC), .FLASH_W(4)
   ) dut (
      .clock(clock), .resetn(resetn), .pressEnable(pe), .key_n(kn),
      .score(score), .miss_count(miss_count),
      .hit_flash(hit_flash), .hit_pulse(hit_pulse)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d required %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_score = 0;
      m_miss  = 0;
      for (int i = 0; i < L; i++) begin
         m_flash[i] = 0; m_hp[i] = 0; m_open[i] = 0; m_got[i] = 0;
         h1[i] = 1; h2[i] = 1; h3[i] = 1;
      end
   endtask

   // one clock edge of the model: a press is seen three edges after the pin
   // falls; hits score one edge after their strobe, strays/misses at once
   task automatic model_edge();
      int nh, ns, nm, s;
      bit pedge;
      nh = 0; ns = 0; nm = 0;
      for (int i = 0; i < L; i++) if (m_hp[i]) nh++;
      for (int i = 0; i < L; i++) begin
         bit hit;
         hit = 0;
         pedge = h3[i] & ~h2[i];
         if (pe[i]) begin
            if (!m_open[i]) m_got[i] = 0;
            if (!m_got[i] && pedge) begin
               hit = 1;
               m_got[i] = 1;
            end
            m_open[i] = 1;
         end else begin
            if (m_open[i] && !m_got[i]) nm++;
            if (!m_open[i] && pedge) ns++;
            m_open[i] = 0;
            m_got[i]  = 0;
         end
         if (m_hp[i])            m_flash[i] = FC;
         else if (m_flash[i] > 0) m_flash[i]--;
         m_hp[i] = hit;
         h3[i] = h2[i]; h2[i] = h1[i]; h1[i] = kn[i];
      end
      s = m_score + nh - PEN * ns;
      m_score = (s < 0) ? 0 : (s > 255) ? 255 : s;
      m_miss  = (m_miss + nm > 255) ? 255 : m_miss + nm;
   endtask

   task automatic step();
      logic [L-1:0] ehp, efl;
      @(posedge clock);
      model_edge();
      @(negedge clock);
      for (int i = 0; i < L; i++) begin
         ehp[i] = m_hp[i];
         efl[i] = (m_flash[i] != 0);
      end
      chk("score", score, m_score);
      chk("miss_count", miss_count, m_miss);
      chk("hit_pulse", hit_pulse, ehp);
      chk("hit_flash", hit_flash, efl);
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      pe = '0;
      kn = '1;
      @(negedge clock);
      resetn = 1'b1;
      model_reset();
   endtask

   task automatic window(input logic [L-1:0] pm, input logic [L-1:0] km);
      pe = pm;
      repeat (2) step();
      kn = ~km;
      repeat (6) step();
      kn = '1;
      repeat (3) step();
      pe = '0;
      repeat (3) step();
   endtask

   initial begin
      int hits, fl, prev, jump;
      model_reset();
      // async reset from power-up
      #1 resetn = 1'b0;
      #1;
      chk("rst_score", score, 0);
      chk("rst_miss", miss_count, 0);
      chk("rst_flash", hit_flash, 0);
      chk("rst_pulse", hit_pulse, 0);
      @(negedge clock);
      resetn = 1'b1;

      // single hit on lane 0
      pe[0] = 1'b1;
      repeat (5) step();
      kn[0] = 1'b0;
      hits = 0; fl = 0;
      for (int c = 0; c < 25; c++) begin
         if (c == 15) pe[0] = 1'b0;
         if (c == 17) kn[0] = 1'b1;
         step();
         hits += int'(hit_pulse[0]);
         fl   += int'(hit_flash[0]);
      end
      chk("single_pulse_cycles", hits, 1);
      chk("single_flash_cycles", fl, FC);
      chk("single_score", score, 1);
      chk("single_miss", miss_count, 0);

      // miss on lane 2
      pe[2] = 1'b1;
      repeat (20) step();
      chk("miss_before", miss_count, 0);
      pe[2] = 1'b0;
      step();
      chk("miss_after", miss_count, 1);
      chk("miss_score", score, 1);

      // stray at score 0 clamps, stray at 3 subtracts
      do_reset();
      kn[1] = 1'b0;
      repeat (6) step();
      kn[1] = 1'b1;
      repeat (3) step();
      chk("stray_clamp0", score, 0);
      window(4'b0111, 4'b0111);
      chk("score_3", score, 3);
      kn[1] = 1'b0;
      repeat (6) step();
      kn[1] = 1'b1;
      repeat (3) step();
      chk("stray_penalty", score, 2);

      // simultaneous presses on lanes 0,1,3; lane 2 misses
      pe = 4'b1111;
      repeat (2) step();
      kn = 4'b0100;
      jump = 0;
      for (int c = 0; c < 8; c++) begin
         prev = int'(score);
         step();
         if (int'(score) - prev > jump) jump = int'(score) - prev;
      end
      kn = '1;
      repeat (3) step();
      pe = '0;
      repeat (3) step();
      chk("simul_jump", jump, 3);
      chk("simul_score", score, 5);
      chk("simul_miss", miss_count, 1);

      // double press in one window scores once
      pe[0] = 1'b1;
      repeat (2) step();
      kn[0] = 1'b0; repeat (4) step();
      kn[0] = 1'b1; repeat (3) step();
      kn[0] = 1'b0; repeat (4) step();
      kn[0] = 1'b1; repeat (3) step();
      pe = '0;
      repeat (3) step();
      chk("double_press", score, 6);

      // random traffic
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < L; i++) begin
            if ($urandom_range(5) == 0) pe[i] = ~pe[i];
            if ($urandom_range(3) == 0) kn[i] = ~kn[i];
         end
         step();
      end
      kn = '1;
      pe = '0;
      repeat (6) step();

      // saturation at 255
      do_reset();
      repeat (63) window(4'b1111, 4'b1111);
      window(4'b0011, 4'b0011);
      chk("score_FE", score, 8'hFE);
      window(4'b0111, 4'b0111);
      chk("score_sat", score, 8'hFF);

      // reset mid-flash with a lane armed, then key held through release
      do_reset();
      repeat (16) window(4'b1111, 4'b1111);
      pe = 4'b1011;
      repeat (2) step();
      kn = 4'b1100;
      repeat (5) step();
      chk("pre_rst_score", score, 8'h42);
      chk("pre_rst_flash0", hit_flash[0], 1);
      #2 resetn = 1'b0;
      pe = '0;
      #1;
      chk("async_score", score, 0);
      chk("async_miss", miss_count, 0);
      chk("async_flash", hit_flash, 0);
      chk("async_pulse", hit_pulse, 0);
      model_reset();
      @(negedge clock);
      resetn = 1'b1;
      hits = 0;
      repeat (12) begin
         step();
         hits += $countones(hit_pulse);
      end
      chk("held_no_hit", hits, 0);
      chk("held_score", score, 0);
      kn = '1;
      repeat (4) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/hit_judge.md
Name: hit_judge

Overview:
- Scoring end of the falling-block game. Consumes the per-lane hit windows (pressEnable) that the block-drawing FSM raises while a block is in the target zone. Also consumes the raw player keys.
- Judges each window as hit or miss, counts stray presses, and maintains the 8-bit score that the drawing FSM renders as two hex digits.
- Drives per-lane hit-flash LEDs.

Parameters:
- LANES, 4, number of lanes; pressEnable and key widths.
- PENALTY, 1, points subtracted per stray press (0 disables the penalty).
- FLASH_CYCLES, 5000000, hit-flash stretch length in clocks (100 ms at 50 MHz).
- FLASH_W, 23, width of the flash counter; must be at least clog2(FLASH_CYCLES+1).

Ports:
- clock  in  1  system clock (50 MHz).
- resetn  in  1  asynchronous, active-low reset.
- pressEnable  in  LANES  per-lane hit window, level, synchronous to clock.
- key_n  in  LANES  raw push-buttons, active-low, asynchronous to clock.
- score  out  8  saturating score; [7:4] is the tens nibble, [3:0] the ones nibble.
- miss_count  out  8  saturating count of closed windows that received no hit.
- hit_flash  out  LANES  per-lane LED, high for FLASH_CYCLES after a hit.
- hit_pulse  out  LANES  one-cycle strobe on each judged hit.

Behaviour:
- Reset is asynchronous, active-low, and may assert mid-operation. It forces: score=0, miss_count=0, hit_flash=0, hit_pulse=0, every lane to IDLE, flash counters to 0, and key synchronizers to 1 (released).
- Key conditioning:
  - key_n passes through a 2-FF synchronizer.
  - press_edge[i] = sync_prev[i] & ~sync[i], i.e. a falling edge of the synchronized key, a single cycle.
  - Latency from the key pin to press_edge is 3 clocks.
  - A held key produces exactly one press_edge.
- Per-lane FSM, evaluated every clock:
  - IDLE:
    - pe=1 and press_edge: go to HIT, hit_pulse=1.
    - pe=1 and no press_edge: go to ARMED.
    - pe=0 and press_edge: stray press; stay in IDLE.
  - ARMED:
    - pe=0: go to IDLE, miss strobe. Window closing takes priority over a press_edge in the same cycle; that press counts as a miss, not a stray.
    - pe=1 and press_edge: go to HIT, hit_pulse=1.
  - HIT:
    - Further press_edge in the same window is ignored (no score change, not a stray).
    - pe=0: go to IDLE.
- Score update, registered one cycle after the strobes:
  - nh = number of hit strobes this cycle (0..LANES).
  - ns = number of stray strobes this cycle.
  - next = score + nh - PENALTY*ns, computed in a 10-bit signed intermediate.
  - Result is clamped to the range 0..255. All lanes are accumulated in the same cycle, so simultaneous events are never lost.
- miss_count adds the number of miss strobes and saturates at 255.
- hit_flash[i]:
  - On hit_pulse[i], the lane counter loads FLASH_CYCLES and the LED goes high.
  - The counter decrements to 0; the LED is high while the counter is nonzero.
  - A new hit during a flash reloads the counter.
- hit_pulse is registered, so it is high for exactly one cycle, one clock after the press_edge.
- pressEnable already-high at reset release: the lane goes to ARMED on the first clock; this is legal.

Decomposition:
- Shared package game_pkg:
  - Lane-state encoding: IDLE=2'd0, ARMED=2'd1, HIT=2'd2.
  - LANES, SCORE_W=8, SCORE_MAX=8'hFF.
- Sub-module lane_judge, instantiated LANES times. It contains the synchronizer, edge detect, lane FSM, and flash counter, and outputs the hit, miss and stray strobes.
- hit_judge itself holds the adder tree, the clamp, and the score and miss_count registers.
- Benches use FLASH_CYCLES=8.

Test Plan:
- Single hit:
  - Stimulus: pe[0] high for 20 cycles; key_n[0] falls at cycle 5 of the window.
  - Required: hit_pulse[0] high exactly 1 cycle; score 0→1; hit_flash[0] high for 8 cycles; miss_count stays 0.
- Miss:
  - Stimulus: pe[2] high 20 cycles then low, no key.
  - Required: miss_count 0→1 one cycle after pe falls; score unchanged.
- Stray with clamp, PENALTY=1:
  - Stimulus: with score=0, press key 1 while pe[1]=0.
  - Required: score stays 0.
  - Stimulus: with score=3, press key 1 while pe[1]=0.
  - Required: score becomes 2.
- Simultaneous events:
  - Stimulus: all four lanes open; keys 0, 1, 3 pressed on the same clock; key 2 never pressed.
  - Required: score +3 in one update; miss_count +1 when the windows close.
- Double press and saturation:
  - Stimulus: two presses in one window.
  - Required: one point only.
  - Stimulus: start at score=8'hFE, hit in 3 lanes.
  - Required: score=8'hFF.
- Reset mid-flash:
  - Stimulus: assert resetn=0 asynchronously while hit_flash=1, score=8'h42 and a lane is ARMED.
  - Required: all outputs 0 immediately.
  - Stimulus: after release, keep the key held.
  - Required: no spurious hit.
